// File: rtl/mac_chain.sv
// mac_chain: folds per-chunk MACs into one message MAC (rotate-left-1 then XOR),
// binds the chunk count into the low bits, and hands the result out on valid/ready.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   chunk_mac/valid/last/ready   input chunk handshake
//   mac_out/valid/ready          finalized message MAC handshake
//   mac_err                      message was force-terminated at MAX_CHUNKS
//   mac_count                    number of chunks in the finalized message
module mac_chain #(
    parameter int N          = 256,
    parameter int MAX_CHUNKS = 16,
    parameter int CW         = $clog2(MAX_CHUNKS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  chunk_mac,
    input  logic          chunk_valid,
    input  logic          chunk_last,
    output logic          chunk_ready,
    output logic [N-1:0]  mac_out,
    output logic          mac_valid,
    input  logic          mac_ready,
    output logic          mac_err,
    output logic [CW-1:0] mac_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam logic [CW-1:0] MAXC = CW'(MAX_CHUNKS);

    state_t          state_q, state_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    mac_out_q, mac_out_d;
    logic            mac_valid_q, mac_valid_d;
    logic            mac_err_q, mac_err_d;
    logic [CW-1:0]   mac_count_q, mac_count_d;

    logic [N-1:0]    acc_fold;
    logic [CW-1:0]   cnt_fold;
    logic            accept;
    logic            forced;

    // Ready depends only on registered state, so no valid->ready path exists.
    assign chunk_ready = (state_q != OUT);
    assign mac_valid   = mac_valid_q;
    assign mac_out     = mac_out_q;
    assign mac_err     = mac_err_q;
    assign mac_count   = mac_count_q;

    assign accept   = chunk_valid && chunk_ready;
    assign acc_fold = {acc_q[N-2:0], acc_q[N-1]} ^ chunk_mac;
    assign cnt_fold = cnt_q + CW'(1);
    // Forced termination only once past the first chunk of a message.
    assign forced   = (state_q == ACCUM) && !chunk_last && (cnt_fold == MAXC);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mac_out_d   = mac_out_q;
        mac_valid_d = mac_valid_q;
        mac_err_d   = mac_err_q;
        mac_count_d = mac_count_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_d = acc_fold;
                    cnt_d = cnt_fold;
                    if (chunk_last || forced) begin
                        state_d     = OUT;
                        mac_out_d   = acc_fold ^ {{(N-CW){1'b0}}, cnt_fold};
                        mac_count_d = cnt_fold;
                        mac_err_d   = forced;
                        mac_valid_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            OUT: begin
                if (mac_ready) begin
                    state_d     = IDLE;
                    mac_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                mac_valid_d = 1'b0;
                acc_d       = '0;
                cnt_d       = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            mac_out_q   <= '0;
            mac_valid_q <= 1'b0;
            mac_err_q   <= 1'b0;
            mac_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mac_out_q   <= mac_out_d;
            mac_valid_q <= mac_valid_d;
            mac_err_q   <= mac_err_d;
            mac_count_q <= mac_count_d;
        end
    end

endmodule

// File: doc/mac_chain.md
Name: mac_chain

Overview:
- Downstream of the per-chunk MAC generator (N-bit key XOR data).
- Consumes one N-bit chunk MAC per accepted transfer and folds it into a running accumulator.
- On the last chunk it finalizes and presents one message MAC, so the result depends on every chunk in the message, on chunk order, and on the message length.
- Valid/ready handshakes on both the input and output sides.

Parameters:
N, 256, width of chunk MAC and final MAC
MAX_CHUNKS, 16, maximum chunks per message; CW = $clog2(MAX_CHUNKS+1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
chunk_mac  input  N  per-chunk MAC from the generator stage
chunk_valid  input  1  chunk_mac/chunk_last valid
chunk_last  input  1  marks final chunk of message
chunk_ready  output  1  block can accept a chunk
mac_out  output  N  finalized message MAC
mac_valid  output  1  mac_out/mac_err/mac_count valid
mac_ready  input  1  consumer accepts mac_out
mac_err  output  1  message was force-terminated at MAX_CHUNKS
mac_count  output  CW  number of chunks in the finalized message

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst and has priority over all other activity.
- Reset values: state=IDLE; acc=0; cnt=0; mac_out=0; mac_valid=0; mac_err=0; mac_count=0; chunk_ready=1 from the first cycle after reset.
- Reset mid-message or while holding output discards everything. No partial MAC is ever emitted.
- Accept condition: accept = chunk_valid && chunk_ready. Inputs are ignored when chunk_ready=0.
- Fold, on each accept:
  - acc_next = {acc[N-2:0], acc[N-1]} ^ chunk_mac, i.e. rotate left by 1, then XOR.
  - cnt_next = cnt + 1.
  - The first chunk of a message therefore gives acc = chunk_mac, since acc=0.
- State IDLE (no chunk yet accepted): chunk_ready=1. An accept with chunk_last=0 folds and goes to ACCUM. An accept with chunk_last=1 folds and goes to OUT.
- State ACCUM: chunk_ready=1.
  - Accept with chunk_last=1 -> OUT.
  - Accept with chunk_last=0 and cnt_next==MAX_CHUNKS -> OUT with err=1 (forced termination).
  - Otherwise stay in ACCUM.
- Finalize, on the transition into OUT:
  - mac_out = acc_next ^ zero-extended cnt_next, binding the length.
  - mac_count = cnt_next.
  - mac_err = forced-termination flag.
  - mac_valid rises the cycle after the accepting edge. Latency is 1 cycle from the last-chunk accept.
- State OUT:
  - chunk_ready=0. Input is back-pressured and no accepts occur.
  - mac_out, mac_count and mac_err are held stable while mac_valid=1 && mac_ready=0.
  - When mac_valid && mac_ready: next cycle mac_valid=0, acc=0, cnt=0, state=IDLE, chunk_ready=1.
  - mac_out, mac_count and mac_err hold their last values after the handshake. They are only meaningful while mac_valid=1.
- Simultaneous events:
  - chunk_valid during OUT is not accepted. The producer must hold the chunk.
  - mac_ready while mac_valid=0 has no effect.
  - chunk_last=1 on the MAX_CHUNKS-th chunk is a normal finalization with mac_err=0.
- Width and arithmetic rules:
  - Rotate is over exactly N bits; the MSB wraps to bit 0.
  - The count is XORed into bits [CW-1:0] only.
  - No carries anywhere.
- No combinational path from chunk_valid to chunk_ready, or from mac_ready to mac_valid.

Test Plan:
- Reset, then a single chunk 0xF0 with last=1 -> chunk_ready=0 and mac_valid=1 the next cycle, mac_out=0xF1, mac_count=1, mac_err=0.
- Chunks 0x1, then 0x2 with last=1, mac_ready held high -> mac_out=0x0^2=0x2, mac_count=2. chunk_ready=1 again the cycle after the output handshake.
- MSB wrap: chunk 1<<255, then 0x0 with last=1 -> acc=0x1, mac_out=0x3.
- Back-pressure: finalize with mac_ready=0 for 5 cycles while chunk_valid=1 -> mac_out stable, chunk_ready=0, no accept. Raise mac_ready -> chunk accepted starts a fresh message (acc=chunk).
- MAX_CHUNKS=4: four chunks of 0x0 with last=0 -> mac_valid with mac_err=1, mac_count=4, mac_out=0x4.
- Assert rst after 2 of 3 chunks -> all outputs return to reset values, no mac_valid. A new single chunk 0xA with last=1 -> mac_out=0xB.
